regfile_mp: RTL

//   Parametrised multi-port integer register file for multi-issue cores.

---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 106 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and the clear handshake.
// The master drives indices, write data and i_clr; the register file drives o_rd and o_busy.
interface regfile_mp_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1
);
   localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [NRD*AW-1:0]   i_rnum;
   logic [NRD*XLEN-1:0] o_rd;
   logic [NWR-1:0]      i_wen;
   logic [NWR*AW-1:0]   i_wnum;
   logic [NWR*XLEN-1:0] i_wd;
   logic                i_clr;
   logic                o_busy;

   modport master (
      output i_rnum, i_wen, i_wnum, i_wd, i_clr,
      input  o_rd, o_busy
   );

   modport slave (
      input  i_rnum, i_wen, i_wnum, i_wd, i_clr,
      output o_rd, o_busy
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass
// and a one-register-per-cycle clear engine used for context flush.
module regfile_mp #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NRD     = 2,
   parameter int unsigned NWR     = 1,
   parameter int unsigned BYPASS  = 1,
   parameter int unsigned ZERO_R0 = 1
) (
   input  logic         i_clk,
   input  logic         i_rstn,
   regfile_mp_if.slave  bus
);
   localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StClear = 1'b1;

   localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

   logic [0:0]      state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NWR-1:0]  wacc;
   logic            busy;
   logic [NRD*XLEN-1:0] rd_data;

   // True for an index that maps to a real, writable register.
   function automatic logic idx_ok(input logic [AW-1:0] idx);
      return (32'(idx) < NREGS) && !((ZERO_R0 != 0) && (idx == '0));
   endfunction

   assign busy = (state_q == StClear);

   always_comb begin
      wacc = '0;
      for (int j = 0; j < NWR; j++) begin
         wacc[j] = bus.i_wen[j] && !busy && idx_ok(bus.i_wnum[j*AW +: AW]);
      end
   end

   always_comb begin
      regs_d  = regs_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      // Ascending port order lets the highest port win on an index collision.
      for (int j = 0; j < NWR; j++) begin
         if (wacc[j]) begin
            regs_d[bus.i_wnum[j*AW +: AW]] = bus.i_wd[j*XLEN +: XLEN];
         end
      end
      case (state_q)
         StIdle: begin
            if (bus.i_clr) begin
               state_d = StClear;
               cnt_d   = '0;
            end
         end
         StClear: begin
            regs_d[cnt_q] = '0;
            if (cnt_q == LastIdx) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NRD; k++) begin
         if (!busy && idx_ok(bus.i_rnum[k*AW +: AW])) begin
            rd_data[k*XLEN +: XLEN] = regs_q[bus.i_rnum[k*AW +: AW]];
            if (BYPASS != 0) begin
               for (int j = 0; j < NWR; j++) begin
                  if (wacc[j] && (bus.i_wnum[j*AW +: AW] == bus.i_rnum[k*AW +: AW])) begin
                     rd_data[k*XLEN +: XLEN] = bus.i_wd[j*XLEN +: XLEN];
                  end
               end
            end
         end
      end
   end

   assign bus.o_rd   = rd_data;
   assign bus.o_busy = busy;

endmodule
